mem_access_unit: RTL

// Memory-stage load/store engine between the execute/memory pipe register and write-back.

---
 rtl/mem_access_unit.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_access_unit                                               |
// | Purpose  : Memory-stage load/store engine. Accepts one op from the       |
// |            execute/memory pipe register, runs a req/gnt/rvalid word      |
// |            transaction to the data cache, aligns/extends load data and   |
// |            emits exactly one write-back record per accepted op.          |
// | Ports    : clk/rst            clock, async active-high reset             |
// |            in_*               memory-stage op (in_valid/in_ready hs)     |
// |            mem_*              word bus to the data cache                 |
// |            out_*              write-back record (1-cycle out_valid)      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int REG_WIDTH = 32,
  parameter int REG_ADDR  = 5,
  parameter int MAX_WAIT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_is_load,
  input  logic                 in_is_store,
  input  logic [1:0]           in_size,
  input  logic                 in_use_unsigned,
  input  logic [REG_WIDTH-1:0] in_address,
  input  logic [REG_WIDTH-1:0] in_wdata,
  input  logic [REG_ADDR-1:0]  in_rd,
  input  logic                 in_is_write_back,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [REG_WIDTH-1:0] mem_addr,
  output logic [3:0]           mem_be,
  output logic [REG_WIDTH-1:0] mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [REG_WIDTH-1:0] mem_rdata,
  output logic                 out_valid,
  output logic [REG_WIDTH-1:0] out_execution_result,
  output logic [REG_WIDTH-1:0] out_mem_data,
  output logic                 out_is_load,
  output logic [REG_ADDR-1:0]  out_rd,
  output logic                 out_is_write_back,
  output logic                 out_misaligned,
  output logic                 out_timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] c_max_wait = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  is_load_q, is_load_d;
  logic [1:0]            size_q, size_d;
  logic                  unsigned_q, unsigned_d;
  logic [REG_WIDTH-1:0]  addr_q, addr_d;
  logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
  logic [REG_ADDR-1:0]   rd_q, rd_d;
  logic                  wb_q, wb_d;

  logic                  out_valid_q, out_valid_d;
  logic [REG_WIDTH-1:0]  out_result_q, out_result_d;
  logic [REG_WIDTH-1:0]  out_data_q, out_data_d;
  logic                  out_is_load_q, out_is_load_d;
  logic [REG_ADDR-1:0]   out_rd_q, out_rd_d;
  logic                  out_wb_q, out_wb_d;
  logic                  out_mis_q, out_mis_d;
  logic                  out_to_q, out_to_d;

  logic                  w_in_mem_op;
  logic                  w_in_fault;
  logic                  w_req;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [REG_WIDTH-1:0]  w_shifted;
  logic [REG_WIDTH-1:0]  w_load_data;

  // A fault only exists for real memory ops; non-mem ops carry arbitrary
  // execution results in in_address.
  assign w_in_mem_op = in_is_load || in_is_store;
  assign w_in_fault  = w_in_mem_op &&
                       ((in_size == 2'd1 && in_address[0]) ||
                        (in_size[1] && (in_address[1:0] != 2'b00)));
  assign w_req       = (state_q == ST_REQ);
  assign w_cnt_inc   = cnt_q + CNT_W'(1);
  assign in_ready    = (state_q == ST_IDLE);

  // Bus fields are forced to zero outside REQ so nothing stale leaks out.
  assign mem_req  = w_req;
  assign mem_we   = w_req && !is_load_q;
  assign mem_addr = w_req ? {addr_q[REG_WIDTH-1:2], 2'b00} : '0;

  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = '0;
    if (w_req) begin
      case (size_q)
        2'd0: begin
          mem_be    = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{wdata_q[7:0]}};
        end
        2'd1: begin
          mem_be    = 4'b0011 << addr_q[1:0];
          mem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = wdata_q;
        end
      endcase
    end
  end

  // Move the addressed lane down to bit 0, then extend to full width.
  always_comb begin
    w_shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    w_load_data = {{(REG_WIDTH-8){w_shifted[7] & ~unsigned_q}}, w_shifted[7:0]};
      2'd1:    w_load_data = {{(REG_WIDTH-16){w_shifted[15] & ~unsigned_q}}, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_load_d     = is_load_q;
    size_d        = size_q;
    unsigned_d    = unsigned_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rd_d          = rd_q;
    wb_d          = wb_q;
    // Record fields default to zero so they read 0 whenever out_valid is low.
    out_valid_d   = 1'b0;
    out_result_d  = '0;
    out_data_d    = '0;
    out_is_load_d = 1'b0;
    out_rd_d      = '0;
    out_wb_d      = 1'b0;
    out_mis_d     = 1'b0;
    out_to_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          is_load_d  = in_is_load;
          size_d     = in_size;
          unsigned_d = in_use_unsigned;
          addr_d     = in_address;
          wdata_d    = in_wdata;
          rd_d       = in_rd;
          wb_d       = in_is_write_back;
          if (w_in_mem_op && !w_in_fault) begin
            state_d = ST_REQ;
          end else begin
            // Non-mem ops and misaligned accesses retire without touching the bus.
            out_valid_d   = 1'b1;
            out_result_d  = in_address;
            out_is_load_d = in_is_load;
            out_rd_d      = in_rd;
            out_wb_d      = in_is_write_back && !w_in_fault;
            out_mis_d     = w_in_fault;
          end
        end
      end
      ST_REQ: begin
        cnt_d = w_cnt_inc;
        if (w_cnt_inc == c_max_wait) begin
          state_d       = ST_IDLE;
          out_valid_d   = 1'b1;
          out_result_d  = addr_q;
          out_is_load_d = is_load_q;
          out_rd_d      = rd_q;
          out_to_d      = 1'b1;
        end else if (mem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = w_cnt_inc;
        // A response arriving on the last allowed cycle still completes.
        if (mem_rvalid) begin
          state_d       = ST_IDLE;
          out_valid_d   = 1'b1;
          out_result_d  = addr_q;
          out_data_d    = is_load_q ? w_load_data : '0;
          out_is_load_d = is_load_q;
          out_rd_d      = rd_q;
          out_wb_d      = wb_q;
        end else if (w_cnt_inc == c_max_wait) begin
          state_d       = ST_IDLE;
          out_valid_d   = 1'b1;
          out_result_d  = addr_q;
          out_is_load_d = is_load_q;
          out_rd_d      = rd_q;
          out_to_d      = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      is_load_q     <= 1'b0;
      size_q        <= 2'd0;
      unsigned_q    <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_q          <= '0;
      wb_q          <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_data_q    <= '0;
      out_is_load_q <= 1'b0;
      out_rd_q      <= '0;
      out_wb_q      <= 1'b0;
      out_mis_q     <= 1'b0;
      out_to_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_load_q     <= is_load_d;
      size_q        <= size_d;
      unsigned_q    <= unsigned_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rd_q          <= rd_d;
      wb_q          <= wb_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_data_q    <= out_data_d;
      out_is_load_q <= out_is_load_d;
      out_rd_q      <= out_rd_d;
      out_wb_q      <= out_wb_d;
      out_mis_q     <= out_mis_d;
      out_to_q      <= out_to_d;
    end
  end

  assign out_valid            = out_valid_q;
  assign out_execution_result = out_result_q;
  assign out_mem_data         = out_data_q;
  assign out_is_load          = out_is_load_q;
  assign out_rd               = out_rd_q;
  assign out_is_write_back    = out_wb_q;
  assign out_misaligned       = out_mis_q;
  assign out_timeout          = out_to_q;

endmodule
`default_nettype wire
